// File: rtl/pool_layer_param.sv
// 2x2 stride-2 max / floor-average pooling over CH parallel channel streams.
// Optional build macro POOL_RELU_EN clamps negative pooled results to zero.
module pool_layer_param #(
  parameter int CH     = 4,
  parameter int DATA_W = 8,
  parameter int MAX_W  = 28,
  parameter int MAX_H  = 28,
  parameter int CW     = $clog2(MAX_W + 1),
  parameter int RW     = $clog2(MAX_H + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CW-1:0]        cfg_in_width,
  input  logic [RW-1:0]        cfg_in_height,
  input  logic                 cfg_mode,
  input  logic                 in_valid,
  input  logic [CH*DATA_W-1:0] in_data,
  output logic                 out_valid,
  output logic [CH*DATA_W-1:0] out_data,
  output logic                 busy,
  output logic                 frame_done
);

  // state  | meaning
  // S_IDLE | waiting for start; in_valid ignored
  // S_RUN  | frame armed, consuming in_valid beats
  // S_DONE | one-cycle frame_done pulse, then back to idle

  localparam int LB_D = MAX_W / 2;
  localparam int LBW  = (LB_D > 1) ? $clog2(LB_D) : 1;
  localparam int SW   = DATA_W + 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       col_q, w_q;
  logic [RW-1:0]       row_q, h_q;
  logic                mode_q;
  logic                beat, last_col, last_row, fire;
  logic [LBW-1:0]      lb_idx;
  logic [CH*DATA_W-1:0] res_all;

  assign beat     = (state_q == S_RUN) && in_valid;
  assign last_col = (col_q == w_q - CW'(1));
  assign last_row = (row_q == h_q - RW'(1));
  assign fire     = beat && col_q[0] && row_q[0];
  assign lb_idx   = LBW'(col_q >> 1);

  always_comb begin
    state_d    = state_q;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (beat && last_col && last_row) state_d = S_DONE;
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      col_q     <= '0;
      row_q     <= '0;
      w_q       <= '0;
      h_q       <= '0;
      mode_q    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state_q   <= state_d;
      out_valid <= fire;
      if (fire) out_data <= res_all;
      if (state_q == S_IDLE && start) begin
        w_q    <= cfg_in_width;
        h_q    <= cfg_in_height;
        mode_q <= cfg_mode;
        col_q  <= '0;
        row_q  <= '0;
      end else if (beat) begin
        if (last_col) begin
          col_q <= '0;
          row_q <= row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
      end
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_ch
    logic signed [DATA_W-1:0] h_reg, pix, res_sel, res;
    logic signed [SW-1:0]     lb [LB_D];
    logic signed [SW-1:0]     hx, px, pair, lbv, quad;

    assign pix = in_data[k*DATA_W +: DATA_W];
    assign hx  = {{2{h_reg[DATA_W-1]}}, h_reg};
    assign px  = {{2{pix[DATA_W-1]}}, pix};
    assign lbv = lb[lb_idx];

    // average mode carries un-normalised sums; the divide happens once at the end
    assign pair    = mode_q ? (hx + px) : ((hx > px) ? hx : px);
    assign quad    = mode_q ? (lbv + pair) : ((lbv > pair) ? lbv : pair);
    assign res_sel = DATA_W'(mode_q ? (quad >>> 2) : quad);

`ifdef POOL_RELU_EN
    assign res = (res_sel < 0) ? '0 : res_sel;
`else
    assign res = res_sel;
`endif

    assign res_all[k*DATA_W +: DATA_W] = res;

    always_ff @(posedge clk) begin
      if (beat) begin
        if (!col_q[0]) h_reg <= pix;
        else if (!row_q[0]) lb[lb_idx] <= pair;
      end
    end
  end

endmodule

// File: tb/tb_pool_layer_param.sv
// Scoreboard bench for pool_layer_param: directed hand vectors plus a frame-array model.
module tb_pool_layer_param;
  localparam int CH = 4, DW = 8, MW = 28, MH = 28, CW = 5, RW = 5;

  logic          clk = 1'b0;
  logic          rst, start, cfg_mode, in_valid;
  logic [CW-1:0] cfg_w;
  logic [RW-1:0] cfg_h;
  logic [CH*DW-1:0] in_data, out_data;
  logic          out_valid, busy, frame_done;

  pool_layer_param #(.CH(CH), .DATA_W(DW), .MAX_W(MW), .MAX_H(MH)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_in_width(cfg_w), .cfg_in_height(cfg_h), .cfg_mode(cfg_mode),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [CH*DW-1:0] data; int cycle; } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int   hand_q[$];
  int   errors = 0, checks = 0, done_seen = 0, done_exp = 0, out_cnt = 0;
  int   fr [CH][MH][MW];

`ifdef POOL_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int model(int k, int r, int c, bit mode);
    int a, b, d, e, m;
    a = fr[k][r-1][c-1]; b = fr[k][r-1][c];
    d = fr[k][r][c-1];   e = fr[k][r][c];
    if (mode) m = (a + b + d + e) >>> 2;
    else begin
      m = a;
      if (b > m) m = b;
      if (d > m) m = d;
      if (e > m) m = e;
    end
    if (RELU && m < 0) m = 0;
    return m;
  endfunction

  // monitor: pops the scoreboard whenever the DUT presents a result
  always @(negedge clk) begin
    if (frame_done === 1'b1) done_seen++;
    if (out_valid === 1'b1) begin
      out_cnt++;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out: got %0h expected no output", out_data);
      end else begin
        mon_e = sb.pop_front();
        chk("out_data", out_data, mon_e.data);
        chk("out_latency", cyc, mon_e.cycle);
      end
    end
  end

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drive_beat(int r, int c, bit mode);
    exp_t e;
    int v;
    @(negedge clk);
    in_valid = 1'b1;
    for (int k = 0; k < CH; k++) in_data[k*DW +: DW] = fr[k][r][c][DW-1:0];
    if (r % 2 == 1 && c % 2 == 1) begin
      if (hand_q.size() > 0) begin
        v = hand_q.pop_front();
        for (int k = 0; k < CH; k++) e.data[k*DW +: DW] = v[DW-1:0];
      end else begin
        for (int k = 0; k < CH; k++) begin
          v = model(k, r, c, mode);
          e.data[k*DW +: DW] = v[DW-1:0];
        end
      end
      e.cycle = cyc + 1;
      sb.push_back(e);
    end
  endtask

  task automatic send_frame(int w, int h, bit mode, int gap_pct, int abort_after, int start_at);
    int n;
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b1; cfg_w = CW'(w); cfg_h = RW'(h); cfg_mode = mode;
    @(negedge clk);
    start = 1'b0;
    cfg_w = CW'(2); cfg_h = RW'(2); cfg_mode = !mode;
    chk("busy_after_start", busy, 1);
    n = 0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        while ($urandom_range(99) < gap_pct) idle();
        drive_beat(r, c, mode);
        n++;
        if (n == start_at) begin
          @(negedge clk);
          in_valid = 1'b0;
          start = 1'b1; cfg_w = CW'(2); cfg_h = RW'(2); cfg_mode = !mode;
          @(negedge clk);
          start = 1'b0;
          chk("busy_ignore_start", busy, 1);
        end
        if (n == abort_after) begin
          @(negedge clk);
          in_valid = 1'b0;
          rst = 1'b1;
          @(negedge clk);
          chk("abort_out_valid", out_valid, 0);
          chk("abort_busy", busy, 0);
          chk("abort_frame_done", frame_done, 0);
          rst = 1'b0;
          repeat (2) idle();
          chk("abort_sb_drained", sb.size(), 0);
          return;
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("frame_done_pulse", frame_done, 1);
    chk("busy_at_done", busy, 0);
    done_exp++;
    @(negedge clk);
    chk("frame_done_single", frame_done, 0);
    repeat (2) idle();
    chk("sb_drained", sb.size(), 0);
  endtask

  task automatic load_4x4();
    int d [4][4] = '{'{1, 5, 2, 3}, '{4, 0, 7, -1}, '{9, 8, -3, -4}, '{6, 2, -2, -8}};
    for (int k = 0; k < CH; k++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) fr[k][r][c] = d[r][c];
  endtask

  task automatic load_2x2(int a, int b, int c, int d);
    for (int k = 0; k < CH; k++) begin
      fr[k][0][0] = a; fr[k][0][1] = b; fr[k][1][0] = c; fr[k][1][1] = d;
    end
  endtask

  task automatic load_random();
    for (int k = 0; k < CH; k++)
      for (int r = 0; r < MH; r++)
        for (int c = 0; c < MW; c++) fr[k][r][c] = int'($urandom_range(255)) - 128;
  endtask

  int neg2, neg128, base;

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    cfg_w = '0; cfg_h = '0; cfg_mode = 1'b0;
    neg2   = RELU ? 0 : -2;
    neg128 = RELU ? 0 : -128;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    rst = 1'b0;

    // in_valid beats in IDLE must not produce anything
    repeat (5) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = $urandom();
    end
    idle();
    chk("idle_busy", busy, 0);
    chk("idle_no_out", out_cnt, 0);

    load_4x4();
    hand_q = '{5, 7, 9, neg2};
    send_frame(4, 4, 1'b0, 0, 0, 0);

    load_2x2(-1, -2, -3, -1);  hand_q = '{neg2};   send_frame(2, 2, 1'b1, 0, 0, 0);
    load_2x2(127, 127, 127, 127); hand_q = '{127}; send_frame(2, 2, 1'b1, 0, 0, 0);
    load_2x2(-128, -128, -128, -128); hand_q = '{neg128}; send_frame(2, 2, 1'b1, 0, 0, 0);

    load_random();
    base = out_cnt;
    send_frame(5, 3, 1'b0, 0, 0, 0);
    chk("count_5x3", out_cnt - base, 2);

    base = out_cnt;
    send_frame(7, 5, 1'b1, 20, 0, 0);
    chk("count_7x5", out_cnt - base, 6);

    base = out_cnt;
    send_frame(28, 28, 1'b1, 0, 0, 0);
    chk("count_28_gapless", out_cnt - base, 196);
    base = out_cnt;
    send_frame(28, 28, 1'b1, 50, 0, 0);
    chk("count_28_gapped", out_cnt - base, 196);
    base = out_cnt;
    send_frame(28, 28, 1'b0, 50, 0, 0);
    chk("count_28_max", out_cnt - base, 196);

    load_4x4();
    hand_q = '{5, 7};
    send_frame(4, 4, 1'b0, 0, 10, 0);
    hand_q = '{5, 7, 9, neg2};
    send_frame(4, 4, 1'b0, 0, 0, 5);

    repeat (3) idle();
    chk("frame_done_count", done_seen, done_exp);
    chk("final_sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
